// File: rtl/spc7110_alu_master.sv
// spc7110_alu_master: runs one multiply/divide through the SPC7110 byte-port ALU:
// mode and argument writes, status polling, then result readback.
module spc7110_alu_master #(
    parameter int BUS_GAP  = 1,
    parameter int POLL_MAX = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_arga,
    input  logic [15:0] cmd_argb,
    output logic        rsp_valid,
    output logic [31:0] rsp_result,
    output logic [15:0] rsp_modulo,
    output logic        rsp_timeout,
    output logic        alu_sfc_enable,
    output logic [3:0]  sfc_alu_port,
    output logic        sfc_rd,
    output logic        sfc_wr,
    output logic [7:0]  sfc_data_out,
    input  logic [7:0]  sfc_data_in
);
    localparam int GW = $clog2(BUS_GAP + 1);
    typedef enum logic [2:0] {IDLE, MODE, WR_A, WR_B, POLL, RD, DONE} state_t;
    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, res_q, res_d;
    logic [15:0]   b_q, b_d, mod_q, mod_d;
    logic [2:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    poll_q, poll_d, data;
    logic [3:0]    port;
    logic          busy_q, busy_d, cv_q, cv_d, cs_q, cs_d, to_q, to_d;
    logic          div, strobe, last_gap;
    logic [2:0]    last_a, last_r;

    assign div            = op_q[1];
    assign last_a         = div ? 3'd3 : 3'd1;
    assign last_r         = div ? 3'd5 : 3'd3;
    assign strobe         = (gap_q == '0) && (state_q inside {MODE, WR_A, WR_B, POLL, RD});
    assign last_gap       = gap_q == GW'(BUS_GAP);
    assign sfc_wr         = strobe && (state_q inside {MODE, WR_A, WR_B});
    assign sfc_rd         = strobe && (state_q inside {POLL, RD});
    assign alu_sfc_enable = strobe;
    assign sfc_alu_port   = strobe ? port : 4'h0;
    assign sfc_data_out   = sfc_wr ? data : 8'h00;
    assign cmd_ready      = state_q == IDLE;
    assign rsp_valid      = state_q == DONE;
    assign rsp_result     = res_q;
    assign rsp_modulo     = mod_q;
    assign rsp_timeout    = to_q;

    always_comb begin
        port = 4'h0;
        data = 8'h00;
        case (state_q)
            MODE: begin port = 4'hE; data = {7'b0, op_q[0]}; end
            WR_A: begin port = {2'b00, idx_q[1:0]}; data = 8'(a_q >> {idx_q[1:0], 3'b000}); end
            WR_B: begin port = {2'b01, div, idx_q[0]}; data = 8'(b_q >> {idx_q[0], 3'b000}); end
            POLL: port = 4'hF;
            RD:   port = {1'b1, idx_q};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        poll_d  = poll_q;
        cv_d    = cv_q;
        cs_d    = cs_q;
        res_d   = res_q;
        mod_d   = mod_q;
        to_d    = to_q;
        gap_d   = '0;
        // read data lands in the first gap cycle; hold it for longer gaps
        busy_d  = (gap_q == GW'(1)) ? sfc_data_in[7] : busy_q;
        if (state_q inside {MODE, WR_A, WR_B, POLL, RD})
            gap_d = last_gap ? '0 : gap_q + GW'(1);
        if (state_q == RD && gap_q == GW'(1)) begin
            for (int i = 0; i < 4; i++)
                if (idx_q == 3'(i)) res_d[8*i +: 8] = sfc_data_in;
            if (idx_q == 3'd4) mod_d[7:0] = sfc_data_in;
            if (idx_q == 3'd5) mod_d[15:8] = sfc_data_in;
        end
        case (state_q)
            IDLE: if (cmd_valid) begin
                op_d    = cmd_op;
                a_d     = cmd_arga;
                b_d     = cmd_argb;
                idx_d   = '0;
                poll_d  = '0;
                res_d   = '0;
                mod_d   = '0;
                to_d    = 1'b0;
                // the port E write clears ALU arguments, so it must precede them
                state_d = (!cv_q || cs_q != cmd_op[0]) ? MODE : WR_A;
            end
            MODE: if (last_gap) begin
                cv_d    = 1'b1;
                cs_d    = op_q[0];
                state_d = WR_A;
            end
            WR_A: if (last_gap) begin
                idx_d   = (idx_q == last_a) ? 3'd0 : idx_q + 3'd1;
                state_d = (idx_q == last_a) ? WR_B : WR_A;
            end
            WR_B: if (last_gap) begin
                idx_d   = (idx_q == 3'd1) ? 3'd0 : idx_q + 3'd1;
                state_d = (idx_q == 3'd1) ? POLL : WR_B;
            end
            POLL: if (last_gap) begin
                if (busy_d) begin
                    poll_d = poll_q + 8'd1;
                    if (poll_q == 8'(POLL_MAX - 1)) begin
                        to_d    = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = RD;
                end
            end
            RD: if (last_gap) begin
                idx_d   = (idx_q == last_r) ? 3'd0 : idx_q + 3'd1;
                state_d = (idx_q == last_r) ? DONE : RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            poll_q  <= '0;
            busy_q  <= 1'b0;
            cv_q    <= 1'b0;
            cs_q    <= 1'b0;
            res_q   <= '0;
            mod_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            poll_q  <= poll_d;
            busy_q  <= busy_d;
            cv_q    <= cv_d;
            cs_q    <= cs_d;
            res_q   <= res_d;
            mod_q   <= mod_d;
            to_q    <= to_d;
        end
    end
endmodule
